// File: rtl/gate_stim_pkg.sv
// Shared types and constants for the gate stimulus sequencer.
// Build option: define GATE_STIM_SELF_CHECK_EN to enable the expected-truth-table self-check.
package gate_stim_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of {b,a} combinations driven per run
    localparam int NUM_STEPS = 4;

    // Default expected gate response, indexed by {b,a}: XOR
    localparam logic [3:0] EXP_TT_DEFAULT = 4'b0110;

endpackage : gate_stim_pkg

// File: rtl/gate_stim_dwell_cnt.sv
// Dwell counter: counts clock cycles while enabled and pulses o_tc on the
// last cycle of each dwell window (count == DWELL_CYCLES-1), then wraps to 0.
module gate_stim_dwell_cnt #(
    parameter int DWELL_CYCLES = 10,
    parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    // Clear has priority so a fresh run always begins at count 0
    assign o_tc    = i_en && !i_clear && at_last;

    // Next count: clear, wrap at the last dwell cycle, or increment
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only; next-state math lives in always_comb.
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : gate_stim_dwell_cnt

// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for a two-input gate: on start it drives {b,a} = 00,01,10,11,
// each for DWELL_CYCLES cycles, samples i_y at the end of every dwell and pulses
// o_done when the run completes.
// Build option: GATE_STIM_SELF_CHECK_EN enables comparison of each sample against
// EXP_TT; without it o_err/o_err_mask read 0 and i_y is ignored.
module gate_stim_seq
    import gate_stim_pkg::*;
#(
    parameter int         DWELL_CYCLES = 10,
    parameter logic [3:0] EXP_TT       = EXP_TT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic [1:0] o_step,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [3:0] o_err_mask
);

    localparam int         CNT_W     = $clog2(DWELL_CYCLES);
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    state_t     state_q, state_d;
    logic [1:0] step_q, step_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       start_acc;
    logic       dwell_clr;
    logic       dwell_en;
    logic       dwell_tc;

    // Abort beats a simultaneous start; start is only heard in IDLE
    assign start_acc = (state_q == ST_IDLE) && i_start && !i_abort;
    assign dwell_en  = (state_q == ST_DRIVE);
    assign dwell_clr = (state_q != ST_DRIVE) || i_abort;

    gate_stim_dwell_cnt #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dwell_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (dwell_clr),
        .i_en    (dwell_en),
        .o_tc    (dwell_tc)
    );

    // FSM next state and next values of the registered gate-side outputs
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_DRIVE;
                    step_d  = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                end else if (dwell_tc) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = '0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + 2'd1;
                        a_d    = step_d[0];
                        b_d    = step_d[1];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_a    = a_q;
    assign o_b    = b_q;
    assign o_step = step_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

`ifdef GATE_STIM_SELF_CHECK_EN
    logic       err_q, err_d;
    logic [3:0] err_mask_q, err_mask_d;

    // Per-step mismatch capture; o_err summarises the mask when a run completes
    always_comb begin
        err_mask_d = err_mask_q;
        err_d      = err_q;
        if (start_acc) begin
            err_mask_d = '0;
        end else if (dwell_tc) begin
            err_mask_d[step_q] = (i_y != EXP_TT[step_q]);
        end
        if (dwell_tc && (step_q == LAST_STEP)) begin
            err_d = |err_mask_d;
        end
    end

    // Self-check result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q      <= 1'b0;
            err_mask_q <= '0;
        end else begin
            err_q      <= err_d;
            err_mask_q <= err_mask_d;
        end
    end

    assign o_err      = err_q;
    assign o_err_mask = err_mask_q;
`else
    // Feedback and expected table are deliberately ignored in this build
    logic unused_y;
    assign unused_y   = i_y ^ (^EXP_TT);
    assign o_err      = 1'b0;
    assign o_err_mask = '0;
`endif

endmodule : gate_stim_seq

// File: tb/tb_gate_stim_seq.sv
// Directed self-checking bench for gate_stim_seq with DWELL_CYCLES=4.
// Self-check expectations follow GATE_STIM_SELF_CHECK_EN (zero when undefined).
module tb_gate_stim_seq;

    localparam int DWELL   = 4;
    localparam int RUN_CYC = 4 * DWELL;
`ifdef GATE_STIM_SELF_CHECK_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       y;
    int         y_mode = 0;   // 0: y=a^b, 1: y stuck 0, 2: y=~(a^b)

    logic       o_a, o_b, o_busy, o_done, o_err;
    logic [1:0] o_step;
    logic [3:0] o_err_mask;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign y = (y_mode == 0) ? (o_a ^ o_b) : (y_mode == 1) ? 1'b0 : ~(o_a ^ o_b);

    gate_stim_seq #(
        .DWELL_CYCLES (DWELL),
        .EXP_TT       (4'b0110)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_y        (y),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_step     (o_step),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_mask (o_err_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, step, b, a}
    function automatic logic [5:0] outs();
        return {o_busy, o_done, o_step, o_b, o_a};
    endfunction

    // Expected outputs on cycle c (1-based) after the start-accept edge
    function automatic logic [5:0] drive_vec(input int c);
        logic [1:0] s;
        s = 2'((c - 1) / DWELL);
        return {1'b1, 1'b0, s, s[1], s[0]};
    endfunction

    function automatic logic [3:0] exp_mask(input logic [3:0] m);
        return SC_EN ? m : 4'b0000;
    endfunction

    // One full run, checking every cycle; optional start glitch at drive cycle glitch_cyc
    task automatic run_full(input string tag, input int glitch_cyc,
                            input logic [3:0] m, input logic e);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= RUN_CYC; c++) begin
            check($sformatf("%s drive c%0d", tag, c), 32'(outs()), 32'(drive_vec(c)));
            if (c == glitch_cyc) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check($sformatf("%s done", tag), 32'(outs()), 32'(6'b010000));
        check($sformatf("%s mask", tag), 32'(o_err_mask), 32'(exp_mask(m)));
        check($sformatf("%s err", tag), 32'(o_err), 32'(SC_EN & e));
        tick();
        check($sformatf("%s idle", tag), 32'(outs()), 32'(6'b000000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        int cyc;
        int done_cyc [3];

        // Reset state
        #1;
        check("reset outs", 32'({o_a, o_b, o_step, o_busy, o_done, o_err, o_err_mask}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post reset idle", 32'(outs()), 32'd0);

        // Basic run, gate behaves as XOR: no mismatches
        y_mode = 0;
        run_full("xor", 0, 4'b0000, 1'b0);

        // Gate stuck at 0: steps 01 and 10 mismatch
        y_mode = 1;
        run_full("stuck0", 0, 4'b0110, 1'b1);

        // Start clears the mask; abort during cycle 6 keeps partial results
        y_mode = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart mask clr", 32'(o_err_mask), 32'd0);
        check("restart err hold", 32'(o_err), 32'(SC_EN));
        repeat (5) tick();
        check("pre-abort c6", 32'(outs()), 32'(drive_vec(6)));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort outs", 32'(outs()), 32'd0);
        check("abort mask", 32'(o_err_mask), 32'(exp_mask(4'b0001)));
        check("abort err", 32'(o_err), 32'(SC_EN));
        done_cnt = 0;
        for (int i = 0; i < 2 * RUN_CYC; i++) begin
            tick();
            if (o_done || o_busy) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);

        // Abort wins over a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort beats start", 32'(outs()), 32'd0);

        // New run restarts at step 0; start pulse in DRIVE is ignored
        y_mode = 0;
        run_full("after abort", 0, 4'b0000, 1'b0);
        run_full("start glitch", 3, 4'b0000, 1'b0);

        // Asynchronous reset during step 2
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre-reset c9", 32'(outs()), 32'(drive_vec(9)));
        #2 rst_n = 1'b0;
        #1;
        check("async reset outs", 32'({o_a, o_b, o_step, o_busy, o_done, o_err, o_err_mask}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("after reset idle", 32'(outs()), 32'd0);

        // Start held high: three back-to-back runs
        start    = 1'b1;
        done_cnt = 0;
        cyc      = 0;
        while (done_cnt < 3 && cyc < 10 * RUN_CYC) begin
            tick();
            cyc++;
            if (o_done) begin
                done_cyc[done_cnt] = cyc;
                done_cnt++;
                if (done_cnt == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("held start dones", 32'(done_cnt), 32'd3);
        if (done_cnt == 3) begin
            check("first done cycle", 32'(done_cyc[0]), 32'(RUN_CYC + 1));
            check("done spacing 1", 32'(done_cyc[1] - done_cyc[0]), 32'(RUN_CYC + 2));
            check("done spacing 2", 32'(done_cyc[2] - done_cyc[1]), 32'(RUN_CYC + 2));
        end
        repeat (2) tick();
        check("held start idle", 32'(outs()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gate_stim_seq
